// File: rtl/mem_stage_hs_if.sv
// Bundle of the EXE->MEM, MEM->WB, data SRAM and bypass signals of mem_stage_hs.
// master is the stage itself, slave is everything around it.
interface mem_stage_hs_if #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5
);
    logic               in_valid;
    logic               in_ready;
    logic [ADDR_W-1:0]  in_pc;
    logic               in_mem_en;
    logic               in_mem_wr;
    logic [1:0]         in_size;
    logic               in_sext;
    logic [ADDR_W-1:0]  in_addr;
    logic [DATA_W-1:0]  in_result;
    logic [DATA_W-1:0]  in_wdata;
    logic               in_reg_we;
    logic [RADDR_W-1:0] in_reg_waddr;
    logic               flush;

    logic               data_req;
    logic               data_wr;
    logic [1:0]         data_size;
    logic [ADDR_W-1:0]  data_addr;
    logic [3:0]         data_wstrb;
    logic [DATA_W-1:0]  data_wdata;
    logic               data_addr_ok;
    logic               data_data_ok;
    logic [DATA_W-1:0]  data_rdata;

    logic               out_valid;
    logic               out_ready;
    logic [ADDR_W-1:0]  out_pc;
    logic               out_reg_we;
    logic [RADDR_W-1:0] out_reg_waddr;
    logic [DATA_W-1:0]  out_wdata;
    logic               out_exc;
    logic [4:0]         out_exccode;
    logic [ADDR_W-1:0]  out_badvaddr;

    logic               byp_valid;
    logic               byp_pending;
    logic [RADDR_W-1:0] byp_waddr;
    logic [DATA_W-1:0]  byp_data;

    modport master (
        input  in_valid, in_pc, in_mem_en, in_mem_wr, in_size, in_sext, in_addr,
               in_result, in_wdata, in_reg_we, in_reg_waddr, flush,
               data_addr_ok, data_data_ok, data_rdata, out_ready,
        output in_ready, data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
               out_valid, out_pc, out_reg_we, out_reg_waddr, out_wdata,
               out_exc, out_exccode, out_badvaddr,
               byp_valid, byp_pending, byp_waddr, byp_data
    );

    modport slave (
        output in_valid, in_pc, in_mem_en, in_mem_wr, in_size, in_sext, in_addr,
               in_result, in_wdata, in_reg_we, in_reg_waddr, flush,
               data_addr_ok, data_data_ok, data_rdata, out_ready,
        input  in_ready, data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
               out_valid, out_pc, out_reg_we, out_reg_waddr, out_wdata,
               out_exc, out_exccode, out_badvaddr,
               byp_valid, byp_pending, byp_waddr, byp_data
    );
endinterface

// File: rtl/mem_stage_hs.sv
// Handshaked MIPS memory stage: one held instruction, one SRAM transaction, load align/extend, bypass.
// Define MEM_ALIGN_CHECK_EN to raise AdEL/AdES on misaligned half/word accesses instead of issuing them.
module mem_stage_hs #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5
) (
    input  logic           clk,
    input  logic           rst,
    mem_stage_hs_if.master bus
);

    typedef enum logic [2:0] {EMPTY, ISSUE, WAIT, DONE, DRAIN} state_t;

    state_t             state;
    state_t             state_nx;
    state_t             accept_state;

    logic [ADDR_W-1:0]  pc_q;
    logic               mem_en_q;
    logic               mem_wr_q;
    logic [1:0]         size_q;
    logic               sext_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic               reg_we_q;
    logic [RADDR_W-1:0] waddr_q;
    logic [DATA_W-1:0]  res_q;

    logic               in_ready_c;
    logic               accept;
    logic               misalign;
    logic               resp_done;
    logic               issuing;
    logic [7:0]         byte_v;
    logic [15:0]        half_v;
    logic [DATA_W-1:0]  load_v;
    logic [3:0]         strb_v;
    logic [DATA_W-1:0]  store_v;

    assign in_ready_c = ((state == EMPTY) || (state == DONE && bus.out_ready)) && !bus.flush;
    assign accept     = bus.in_valid && in_ready_c;
    assign issuing    = (state == ISSUE);
    assign resp_done  = (issuing && bus.data_addr_ok && bus.data_data_ok) ||
                        (state == WAIT && bus.data_data_ok);

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = bus.in_mem_en &&
                      (((bus.in_size == 2'd1) && bus.in_addr[0]) ||
                       (bus.in_size[1] && (bus.in_addr[1:0] != 2'b00)));
`else
    assign misalign = 1'b0;
`endif

    assign accept_state = (bus.in_mem_en && !misalign) ? ISSUE : DONE;

    always_ff @(posedge clk) begin
        if (rst) state <= EMPTY;
        else     state <= state_nx;
    end

    // A response arriving in the same cycle as the flush is already consumed, so no drain is needed.
    always_comb begin
        state_nx = state;
        case (state)
            EMPTY: if (accept) state_nx = accept_state;
            ISSUE: begin
                if (bus.flush)
                    state_nx = (bus.data_addr_ok && !bus.data_data_ok) ? DRAIN : EMPTY;
                else if (bus.data_addr_ok)
                    state_nx = bus.data_data_ok ? DONE : WAIT;
            end
            WAIT: begin
                if (bus.flush)             state_nx = bus.data_data_ok ? EMPTY : DRAIN;
                else if (bus.data_data_ok) state_nx = DONE;
            end
            DONE: begin
                if (bus.flush)          state_nx = EMPTY;
                else if (bus.out_ready) state_nx = accept ? accept_state : EMPTY;
            end
            DRAIN: if (bus.data_data_ok) state_nx = EMPTY;
            default: state_nx = EMPTY;
        endcase
    end

    always_comb begin
        byte_v = bus.data_rdata[{addr_q[1:0], 3'b000} +: 8];
        half_v = bus.data_rdata[{addr_q[1], 4'b0000} +: 16];
        case (size_q)
            2'd0:    load_v = {{(DATA_W-8){sext_q & byte_v[7]}}, byte_v};
            2'd1:    load_v = {{(DATA_W-16){sext_q & half_v[15]}}, half_v};
            default: load_v = bus.data_rdata;
        endcase
    end

    always_comb begin
        case (size_q)
            2'd0: begin
                strb_v  = 4'b0001 << addr_q[1:0];
                store_v = {4{wdata_q[7:0]}};
            end
            2'd1: begin
                strb_v  = addr_q[1] ? 4'b1100 : 4'b0011;
                store_v = {2{wdata_q[15:0]}};
            end
            default: begin
                strb_v  = 4'b1111;
                store_v = wdata_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= '0;
            mem_en_q <= 1'b0;
            mem_wr_q <= 1'b0;
            size_q   <= 2'd0;
            sext_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            reg_we_q <= 1'b0;
            waddr_q  <= '0;
            res_q    <= '0;
        end else if (accept) begin
            pc_q     <= bus.in_pc;
            mem_en_q <= bus.in_mem_en;
            mem_wr_q <= bus.in_mem_wr;
            size_q   <= bus.in_size;
            sext_q   <= bus.in_sext;
            addr_q   <= bus.in_addr;
            wdata_q  <= bus.in_wdata;
            reg_we_q <= bus.in_reg_we && !misalign;
            waddr_q  <= bus.in_reg_waddr;
            res_q    <= bus.in_result;
        end else if (resp_done && !bus.flush && !mem_wr_q) begin
            res_q    <= load_v;
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    logic              exc_q;
    logic [4:0]        exccode_q;
    logic [ADDR_W-1:0] badvaddr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            exc_q      <= 1'b0;
            exccode_q  <= 5'd0;
            badvaddr_q <= '0;
        end else if (accept) begin
            exc_q      <= misalign;
            exccode_q  <= misalign ? (bus.in_mem_wr ? 5'd5 : 5'd4) : 5'd0;
            badvaddr_q <= misalign ? bus.in_addr : '0;
        end
    end

    assign bus.out_exc      = (state == DONE) && exc_q;
    assign bus.out_exccode  = (state == DONE) ? exccode_q : 5'd0;
    assign bus.out_badvaddr = (state == DONE) ? badvaddr_q : '0;
`else
    assign bus.out_exc      = 1'b0;
    assign bus.out_exccode  = 5'd0;
    assign bus.out_badvaddr = '0;
`endif

    assign bus.in_ready      = in_ready_c;

    assign bus.data_req      = issuing;
    assign bus.data_wr       = issuing && mem_wr_q;
    assign bus.data_size     = issuing ? size_q : 2'd0;
    assign bus.data_addr     = issuing ? addr_q : '0;
    assign bus.data_wstrb    = (issuing && mem_wr_q) ? strb_v : 4'b0000;
    assign bus.data_wdata    = (issuing && mem_wr_q) ? store_v : '0;

    assign bus.out_valid     = (state == DONE);
    assign bus.out_pc        = pc_q;
    assign bus.out_reg_we    = reg_we_q;
    assign bus.out_reg_waddr = waddr_q;
    assign bus.out_wdata     = res_q;

    // A load's bypass value is only real once the response has landed in DONE.
    assign bus.byp_valid     = (state == ISSUE || state == WAIT || state == DONE) && reg_we_q;
    assign bus.byp_pending   = bus.byp_valid && mem_en_q && !mem_wr_q && (state != DONE);
    assign bus.byp_waddr     = waddr_q;
    assign bus.byp_data      = res_q;

endmodule
